axis_trace_packet_serializer: RTL and testbench
===============================================

Name: axis_trace_packet_serializer

Overview:
- Sits directly downstream of the monitoring block's AXI-Stream master output and upstream of the AXI DMA/FIFO.
- Accepts one wide trace packet per handshake and emits it as RATIO = IN_WIDTH/OUT_WIDTH narrow beats, least-significant slice first.
- Preserves packet boundaries: an input tlast is propagated to the final narrow beat only.
- Keeps free-running statistics (beats sent, sink stall cycles) for host readback.

Parameters:
- IN_WIDTH, 1024, width of input packet (s_axis_tdata); must be an integer multiple of OUT_WIDTH (elaboration-time $error otherwise).
- OUT_WIDTH, 64, width of output beat (m_axis_tdata).
- CNT_WIDTH, 32, width of statistics counters.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- s_axis_tvalid  input  1  wide packet valid
- s_axis_tready  output  1  serializer can accept a packet
- s_axis_tdata  input  IN_WIDTH  wide packet
- s_axis_tlast  input  1  packet is end of frame
- m_axis_tvalid  output  1  narrow beat valid
- m_axis_tready  input  1  sink accepts beat
- m_axis_tdata  output  OUT_WIDTH  narrow beat
- m_axis_tlast  output  1  last beat of a frame
- stats_clear  input  1  synchronous clear of statistics counters
- beat_count  output  CNT_WIDTH  narrow beats handshaken since reset/clear
- stall_count  output  CNT_WIDTH  cycles with m_axis_tvalid=1 and m_axis_tready=0

Behaviour:
- Reset (async assert, sync release): state=IDLE, s_axis_tready=1, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, beat index=0, beat_count=0, stall_count=0. Holding register cleared.
- States:
  - IDLE: s_axis_tready=1, m_axis_tvalid=0.
  - SEND: m_axis_tvalid=1, m_axis_tdata = hold[idx*OUT_WIDTH +: OUT_WIDTH].
- IDLE -> SEND: on s_axis_tvalid & s_axis_tready. Latch tdata/tlast into hold, set idx=0. First beat is valid on the next cycle (latency 1).
- In SEND, on m_axis_tvalid & m_axis_tready:
  - idx < RATIO-1: idx increments.
  - idx == RATIO-1 (final beat): the packet is complete.
- Back-to-back transfer: s_axis_tready is 1 in SEND only during the final-beat handshake cycle (combinational from m_axis_tready). If s_axis_tvalid is also 1 in that cycle, the new packet is latched, idx=0, and the state stays SEND with no bubble. Otherwise the state returns to IDLE.
- m_axis_tlast = latched tlast & (idx == RATIO-1). It is 0 on all other beats.
- m_axis_tdata/tvalid/tlast stay stable while tvalid=1 and tready=0 (AXI-S rule). A beat is never skipped or repeated.
- RATIO==1 is legal: the block degenerates to a one-stage register slice with full throughput.
- idx width is clog2(RATIO) (minimum 1 bit). idx never exceeds RATIO-1.
- beat_count increments on each m handshake. stall_count increments on each m_axis_tvalid & ~m_axis_tready cycle.
- Both counters wrap modulo 2^CNT_WIDTH.
- stats_clear zeroes both counters and has priority over an increment in the same cycle. It does not affect the datapath.
- Reset mid-packet: the in-flight packet is discarded, outputs return to reset values immediately, and no partial tlast is emitted.
- Throughput: one input packet per RATIO cycles when the sink is always ready.

Test Plan:
- IN_WIDTH=128, OUT_WIDTH=32, m_axis_tready=1, one packet 0x4444_4444_3333_3333_2222_2222_1111_1111 with tlast=1 -> beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 on cycles 1-4 after accept; tlast only on 4th beat; beat_count=4.
- Two packets presented back-to-back, sink always ready -> 8 consecutive valid beats with no bubble; s_axis_tready high only in the final-beat cycles; beat_count=8, stall_count=0.
- Sink deasserts tready for 3 cycles during beat 2 -> beat 2 data held stable for 4 cycles; stall_count=3; s_axis_tready stays 0 throughout.
- Input tlast=0 -> no output beat has tlast=1. Then stats_clear asserted during a handshake -> counters read 0 next cycle.
- rst_n pulsed low after beat 1 of 4 -> m_axis_tvalid=0 immediately; after release s_axis_tready=1, and the next packet starts at slice 0.
- OUT_WIDTH=IN_WIDTH=64, continuous valid/ready -> one beat per cycle after 1-cycle latency, data equal to input, tlast passed through.

Source files
------------

// File: rtl/axis_trace_packet_serializer.sv
// Wide-to-narrow AXI-Stream serializer for trace packets: one IN_WIDTH packet
// in, RATIO OUT_WIDTH beats out (LS slice first), tlast on the final beat only.
module axis_trace_packet_serializer #(
  parameter int IN_WIDTH  = 1024,
  parameter int OUT_WIDTH = 64,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic [IN_WIDTH-1:0]  s_axis_tdata,
  input  logic                 s_axis_tlast,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [OUT_WIDTH-1:0] m_axis_tdata,
  output logic                 m_axis_tlast,
  input  logic                 stats_clear,
  output logic [CNT_WIDTH-1:0] beat_count,
  output logic [CNT_WIDTH-1:0] stall_count
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  if ((IN_WIDTH % OUT_WIDTH) != 0) begin : g_bad_ratio
    $error("IN_WIDTH must be an integer multiple of OUT_WIDTH");
  end

  typedef enum logic {IDLE, SEND} state_e;

  state_e               state_q, state_d;
  logic [IN_WIDTH-1:0]  hold_q, hold_d;
  logic                 last_q, last_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_WIDTH-1:0] beat_count_q, beat_count_d;
  logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;
  logic                 final_beat, m_hs, s_hs;

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    last_d        = last_q;
    idx_d         = idx_q;
    final_beat    = (state_q == SEND) && (idx_q == LAST_IDX);
    m_axis_tvalid = (state_q == SEND);
    // Ready re-opens during the final-beat handshake so the next packet lands with no bubble.
    s_axis_tready = (state_q == IDLE) || (final_beat && m_axis_tready);
    m_axis_tlast  = final_beat && last_q;
    m_hs          = m_axis_tvalid && m_axis_tready;
    s_hs          = s_axis_tvalid && s_axis_tready;

    if (m_hs && !final_beat) idx_d = idx_q + 1'b1;

    if (s_hs) begin
      hold_d  = s_axis_tdata;
      last_d  = s_axis_tlast;
      idx_d   = '0;
      state_d = SEND;
    end else if (m_hs && final_beat) begin
      state_d = IDLE;
    end

    beat_count_d  = stats_clear ? '0 : beat_count_q + CNT_WIDTH'(m_hs);
    stall_count_d = stats_clear ? '0 :
                    stall_count_q + CNT_WIDTH'(m_axis_tvalid && !m_axis_tready);
  end

  always_comb begin
    m_axis_tdata = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (idx_q == IDX_W'(i)) m_axis_tdata = hold_q[i*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      hold_q        <= '0;
      last_q        <= 1'b0;
      idx_q         <= '0;
      beat_count_q  <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      last_q        <= last_d;
      idx_q         <= idx_d;
      beat_count_q  <= beat_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign beat_count  = beat_count_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_axis_trace_packet_serializer.sv
// Bench for the trace serializer: a 128->32 instance and a 64->64 register-slice
// instance, checked every cycle against a beat-queue model plus literal spot checks.
module tb_axis_trace_packet_serializer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance 0: 128 -> 32 (RATIO 4)
  logic         s_tvalid0, s_tready0, s_tlast0, m_tvalid0, m_tready0, m_tlast0, clr0;
  logic [127:0] s_tdata0;
  logic [31:0]  m_tdata0, bcnt0, scnt0;
  // Instance 1: 64 -> 64 (RATIO 1)
  logic         s_tvalid1, s_tready1, s_tlast1, m_tvalid1, m_tready1, m_tlast1, clr1;
  logic [63:0]  s_tdata1, m_tdata1;
  logic [31:0]  bcnt1, scnt1;

  axis_trace_packet_serializer #(.IN_WIDTH(128), .OUT_WIDTH(32), .CNT_WIDTH(32)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(s_tvalid0), .s_axis_tready(s_tready0), .s_axis_tdata(s_tdata0),
    .s_axis_tlast(s_tlast0), .m_axis_tvalid(m_tvalid0), .m_axis_tready(m_tready0),
    .m_axis_tdata(m_tdata0), .m_axis_tlast(m_tlast0), .stats_clear(clr0),
    .beat_count(bcnt0), .stall_count(scnt0));

  axis_trace_packet_serializer #(.IN_WIDTH(64), .OUT_WIDTH(64), .CNT_WIDTH(32)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(s_tvalid1), .s_axis_tready(s_tready1), .s_axis_tdata(s_tdata1),
    .s_axis_tlast(s_tlast1), .m_axis_tvalid(m_tvalid1), .m_axis_tready(m_tready1),
    .m_axis_tdata(m_tdata1), .m_axis_tlast(m_tlast1), .stats_clear(clr1),
    .beat_count(bcnt1), .stall_count(scnt1));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: per instance, a FIFO of beats still owed to the sink plus counters.
  logic [63:0] exp_data [2][256];
  logic        exp_last [2][256];
  int          head [2] = '{0, 0};
  int          tail [2] = '{0, 0};
  logic [31:0] mdl_bc [2] = '{0, 0};
  logic [31:0] mdl_sc [2] = '{0, 0};

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic         mv, mr, ml, sv, sr, sl, cl, exp_sr, mhs, shs;
      logic [63:0]  md;
      logic [127:0] sd, slice;
      logic [31:0]  bc, sc;
      int           n, ratio, ow;
      if (d == 0) begin
        mv = m_tvalid0; mr = m_tready0; ml = m_tlast0; md = {32'h0, m_tdata0};
        sv = s_tvalid0; sr = s_tready0; sl = s_tlast0; sd = s_tdata0;
        cl = clr0; bc = bcnt0; sc = scnt0; ratio = 4; ow = 32;
      end else begin
        mv = m_tvalid1; mr = m_tready1; ml = m_tlast1; md = m_tdata1;
        sv = s_tvalid1; sr = s_tready1; sl = s_tlast1; sd = {64'h0, s_tdata1};
        cl = clr1; bc = bcnt1; sc = scnt1; ratio = 1; ow = 64;
      end
      n = tail[d] - head[d];
      if (!rst_n) begin
        chk($sformatf("rst_m_tvalid%0d", d), {63'h0, mv}, 64'h0);
        chk($sformatf("rst_s_tready%0d", d), {63'h0, sr}, 64'h1);
        chk($sformatf("rst_m_tlast%0d", d), {63'h0, ml}, 64'h0);
        chk($sformatf("rst_m_tdata%0d", d), md, 64'h0);
        chk($sformatf("rst_beat_count%0d", d), {32'h0, bc}, 64'h0);
        chk($sformatf("rst_stall_count%0d", d), {32'h0, sc}, 64'h0);
        head[d] = 0; tail[d] = 0; mdl_bc[d] = '0; mdl_sc[d] = '0;
      end else begin
        exp_sr = (n == 0) || (n == 1 && mr);
        chk($sformatf("m_tvalid%0d", d), {63'h0, mv}, {63'h0, n != 0});
        chk($sformatf("s_tready%0d", d), {63'h0, sr}, {63'h0, exp_sr});
        if (n != 0) begin
          chk($sformatf("m_tdata%0d", d), md, exp_data[d][head[d] % 256]);
          chk($sformatf("m_tlast%0d", d), {63'h0, ml}, {63'h0, exp_last[d][head[d] % 256]});
        end else begin
          chk($sformatf("idle_m_tlast%0d", d), {63'h0, ml}, 64'h0);
        end
        chk($sformatf("beat_count%0d", d), {32'h0, bc}, {32'h0, mdl_bc[d]});
        chk($sformatf("stall_count%0d", d), {32'h0, sc}, {32'h0, mdl_sc[d]});
        mhs = (n != 0) && mr;
        shs = sv && exp_sr;
        if (mhs) head[d]++;
        if (shs) begin
          for (int k = 0; k < ratio; k++) begin
            slice = (sd >> (k * ow)) & ((128'h1 << ow) - 128'h1);
            exp_data[d][tail[d] % 256] = slice[63:0];
            exp_last[d][tail[d] % 256] = sl && (k == ratio - 1);
            tail[d]++;
          end
        end
        if (cl) begin
          mdl_bc[d] = '0; mdl_sc[d] = '0;
        end else begin
          mdl_bc[d] += 32'(mhs);
          mdl_sc[d] += 32'((n != 0) && !mr);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present a packet on instance 0 and hold it until the handshake edge.
  task automatic send_pkt(input logic [127:0] data, input logic last);
    bit done = 0;
    s_tvalid0 = 1'b1; s_tdata0 = data; s_tlast0 = last;
    for (int i = 0; i < 20 && !done; i++) begin
      if (s_tready0) done = 1;
      cyc();
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL send_pkt_timeout: got s_tready=0 expected 1 within 20 cycles");
    end
    s_tvalid0 = 1'b0;
  endtask

  localparam logic [127:0] P1 = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
  localparam logic [127:0] P2 = 128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF;
  localparam logic [127:0] P3 = 128'hA5A5_0001_5A5A_0002_0F0F_0003_F0F0_0004;

  logic [31:0] p1_beats [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
  logic [63:0] pass_vals [6] = '{64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000,
                                 64'h1, 64'h8000_0000_0000_0000, 64'hDEAD_BEEF_0BAD_F00D,
                                 64'h5555_AAAA_5555_AAAA};

  initial begin
    rst_n = 1'b0;
    s_tvalid0 = 0; s_tdata0 = '0; s_tlast0 = 0; m_tready0 = 1; clr0 = 0;
    s_tvalid1 = 0; s_tdata1 = '0; s_tlast1 = 0; m_tready1 = 1; clr1 = 0;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    // Single packet, sink always ready
    send_pkt(P1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("p1_beat%0d", k), {32'h0, m_tdata0}, {32'h0, p1_beats[k]});
      chk($sformatf("p1_tlast%0d", k), {63'h0, m_tlast0}, {63'h0, k == 3});
      cyc();
    end
    chk("p1_beat_count", {32'h0, bcnt0}, 64'd4);
    chk("p1_idle_tvalid", {63'h0, m_tvalid0}, 64'h0);

    // Back-to-back packets; second has tlast=0
    clr0 = 1; cyc(); clr0 = 0;
    chk("clr_beat_count", {32'h0, bcnt0}, 64'd0);
    send_pkt(P2, 1'b1);
    send_pkt(P3, 1'b0);
    repeat (4) cyc();
    chk("b2b_beat_count", {32'h0, bcnt0}, 64'd8);
    chk("b2b_stall_count", {32'h0, scnt0}, 64'd0);

    // Sink stall for 3 cycles on beat 2
    clr0 = 1; cyc(); clr0 = 0;
    send_pkt(P1, 1'b1);
    cyc();
    m_tready0 = 0;
    for (int k = 0; k < 3; k++) begin
      chk("stall_hold_data", {32'h0, m_tdata0}, 64'h22222222);
      chk("stall_s_tready", {63'h0, s_tready0}, 64'h0);
      cyc();
    end
    m_tready0 = 1;
    chk("stall_release_data", {32'h0, m_tdata0}, 64'h22222222);
    repeat (3) cyc();
    chk("stall_count_3", {32'h0, scnt0}, 64'd3);
    chk("stall_beat_count", {32'h0, bcnt0}, 64'd4);

    // stats_clear coinciding with a handshake
    send_pkt(P2, 1'b0);
    clr0 = 1; cyc(); clr0 = 0;
    chk("clr_prio_beat", {32'h0, bcnt0}, 64'd0);
    chk("clr_prio_stall", {32'h0, scnt0}, 64'd0);
    repeat (4) cyc();

    // Reset mid-packet
    send_pkt(P1, 1'b1);
    cyc();
    rst_n = 1'b0;
    #1;
    chk("midrst_tvalid", {63'h0, m_tvalid0}, 64'h0);
    chk("midrst_tlast", {63'h0, m_tlast0}, 64'h0);
    cyc();
    rst_n = 1'b1;
    chk("postrst_s_tready", {63'h0, s_tready0}, 64'h1);
    send_pkt(P2, 1'b1);
    chk("postrst_slice0", {32'h0, m_tdata0}, 64'h89ABCDEF);
    repeat (5) cyc();

    // RATIO=1 instance: continuous stream, one beat per cycle
    s_tvalid1 = 1;
    for (int k = 0; k < 6; k++) begin
      s_tdata1 = pass_vals[k];
      s_tlast1 = k[0];
      cyc();
      chk($sformatf("pass_data%0d", k), m_tdata1, pass_vals[k]);
      chk($sformatf("pass_tlast%0d", k), {63'h0, m_tlast1}, {63'h0, k[0]});
    end
    s_tvalid1 = 0;
    cyc();
    chk("pass_beat_count", {32'h0, bcnt1}, 64'd6);
    chk("pass_idle_tvalid", {63'h0, m_tvalid1}, 64'h0);
    repeat (2) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
